hycube_port_arbiter: RTL and testbench

HYCUBE_PORT_ARBITER -- requirements
Module: hycube_port_arbiter

---
 rtl/hycube_port_arbiter_pkg.sv | 33 +++
 rtl/hycube_port_arbiter_if.sv | 47 ++++
 rtl/hycube_rr_arb2.sv | 43 ++++
 rtl/hycube_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_hycube_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hycube_port_arbiter_pkg.sv
// Shared types and constants for the HyCUBE configuration-port arbiter.
// Holds the FSM state encoding, the hc_da_valid phase codes, the read-timeout
// error word and the latched transaction payload.
package hycube_port_arbiter_pkg;

    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned ADDR_WIDTH = 16;
    localparam int unsigned CNT_WIDTH  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_WDATA  = 3'd2,
        ST_RDWAIT = 3'd3,
        ST_EXEC   = 3'd4
    } state_e;

    // hc_da_valid phase codes
    localparam logic [1:0] DA_NONE = 2'b00;
    localparam logic [1:0] DA_ADDR = 2'b10;
    localparam logic [1:0] DA_DATA = 2'b01;

    // Returned on rdata when a read never comes back
    localparam logic [15:0] ERR_WORD = 16'hDEAD;

    // Operands captured at grant time
    typedef struct packed {
        logic                  id;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
    } txn_t;

endpackage

// File: rtl/hycube_port_arbiter_if.sv
// Requester + HyCUBE array side signal bundle of the port arbiter.
//   slave  : the arbiter (samples req/we/addr_i/wdata_i/start_req and the
//            array returns, drives gnt/read return/busy and the hc_* bus)
//   master : the requesters and array model on the other side
interface hycube_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    import hycube_port_arbiter_pkg::*;

    // requester side
    logic [NUM_REQ-1:0]                  req;
    logic [NUM_REQ-1:0]                  we;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  addr_i;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  wdata_i;
    logic [NUM_REQ-1:0]                  start_req;
    logic [NUM_REQ-1:0]                  gnt;
    logic [DATA_WIDTH-1:0]               rdata;
    logic                                rvalid;
    logic                                rid;
    logic                                rerr;
    logic                                busy_exec;

    // array side
    logic [DATA_WIDTH-1:0]               hc_data;
    logic                                hc_data_or_addr;
    logic                                hc_read_write;
    logic [1:0]                          hc_da_valid;
    logic                                hc_start_exec;
    logic [DATA_WIDTH-1:0]               hc_rdata;
    logic                                hc_rdata_valid;
    logic                                hc_exec_end;

    modport slave (
        input  req, we, addr_i, wdata_i, start_req,
        input  hc_rdata, hc_rdata_valid, hc_exec_end,
        output gnt, rdata, rvalid, rid, rerr, busy_exec,
        output hc_data, hc_data_or_addr, hc_read_write, hc_da_valid, hc_start_exec
    );

    modport master (
        output req, we, addr_i, wdata_i, start_req,
        output hc_rdata, hc_rdata_valid, hc_exec_end,
        input  gnt, rdata, rvalid, rid, rerr, busy_exec,
        input  hc_data, hc_data_or_addr, hc_read_write, hc_da_valid, hc_start_exec
    );

endinterface

// File: rtl/hycube_rr_arb2.sv
// Two-input round-robin arbiter.
//   clk, rstn : clock, async active-low reset (pointer back to requester 0)
//   req_i     : request vector
//   en_i      : arbitration allowed this cycle
//   gnt_o_c   : combinational one-hot grant; pointer moves past the winner
module hycube_rr_arb2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o_c
);

    logic ptr_q;
    logic ptr_d;

    // Pointer requester wins ties; after a grant the other one gets priority
    always_comb begin
        gnt_o_c = 2'b00;
        ptr_d   = ptr_q;
        if (en_i) begin
            if (req_i[ptr_q]) begin
                gnt_o_c[ptr_q] = 1'b1;
            end else if (req_i[~ptr_q]) begin
                gnt_o_c[~ptr_q] = 1'b1;
            end
        end
        if (gnt_o_c[0]) begin
            ptr_d = 1'b1;
        end else if (gnt_o_c[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/hycube_port_arbiter.sv
// Arbitrates the SPI (0) and parallel-scan (1) requesters onto the HyCUBE
// configuration bus and sequences array execution.
//   clk, rstn : clock, async active-low reset
//   bus       : requester handshake (req/we/addr_i/wdata_i/start_req ->
//               gnt/rdata/rvalid/rid/rerr/busy_exec) and array bus
//               (hc_data/hc_data_or_addr/hc_read_write/hc_da_valid/
//               hc_start_exec <- hc_rdata/hc_rdata_valid/hc_exec_end)
// All outputs are registered and reflect the state being entered.
module hycube_port_arbiter
    import hycube_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned RD_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rstn,
    hycube_port_arbiter_if.slave bus
);

    state_e                 state_q, state_d;
    txn_t                   txn_q, txn_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   start_pend_q, start_pend_d;
    logic                   rst_done_q;

    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   rvalid_q, rvalid_d;
    logic                   rid_q, rid_d;
    logic                   rerr_q, rerr_d;
    logic                   busy_q, busy_d;
    logic [DATA_WIDTH-1:0]  hc_data_q, hc_data_d;
    logic                   hc_doa_q, hc_doa_d;
    logic                   hc_rw_q, hc_rw_d;
    logic [1:0]             hc_da_q, hc_da_d;
    logic                   hc_start_q, hc_start_d;

    logic                   start_any_c;
    logic                   arb_en_c;
    logic [NUM_REQ-1:0]     arb_gnt_c;

    // Sticky start request, including one arriving this very cycle
    assign start_any_c = start_pend_q | (|bus.start_req);

    // Grants only from IDLE, never while a start is owed, never on the first edge after reset
    assign arb_en_c = (state_q == ST_IDLE) && !start_any_c && rst_done_q;

    hycube_rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rstn    (rstn),
        .req_i   (bus.req),
        .en_i    (arb_en_c),
        .gnt_o_c (arb_gnt_c)
    );

    // Next state, then registered outputs derived from the state being entered
    always_comb begin
        state_d      = state_q;
        txn_d        = txn_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        start_pend_d = start_any_c;
        gnt_d        = '0;
        rvalid_d     = 1'b0;
        rid_d        = 1'b0;
        rerr_d       = 1'b0;
        rdata_d      = '0;
        hc_start_d   = 1'b0;
        hc_data_d    = '0;
        hc_doa_d     = 1'b0;
        hc_rw_d      = 1'b0;
        hc_da_d      = DA_NONE;

        unique case (state_q)
            ST_IDLE: begin
                if (start_any_c) begin
                    start_pend_d = 1'b0;
                    hc_start_d   = 1'b1;
                    state_d      = ST_EXEC;
                end else if (arb_gnt_c != 2'b00) begin
                    gnt_d      = arb_gnt_c;
                    txn_d.id   = arb_gnt_c[1];
                    txn_d.we   = bus.we[arb_gnt_c[1]];
                    txn_d.addr = bus.addr_i[arb_gnt_c[1]];
                    wdata_d    = bus.wdata_i[arb_gnt_c[1]];
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                cnt_d   = '0;
                state_d = txn_q.we ? ST_WDATA : ST_RDWAIT;
            end
            ST_WDATA: begin
                state_d = ST_IDLE;
            end
            ST_RDWAIT: begin
                if (bus.hc_rdata_valid) begin
                    rvalid_d = 1'b1;
                    rid_d    = txn_q.id;
                    rdata_d  = bus.hc_rdata;
                    state_d  = ST_IDLE;
                end else if (cnt_q == CNT_WIDTH'(RD_TIMEOUT - 1)) begin
                    rvalid_d = 1'b1;
                    rid_d    = txn_q.id;
                    rerr_d   = 1'b1;
                    rdata_d  = DATA_WIDTH'(ERR_WORD);
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_EXEC: begin
                if (bus.hc_exec_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_ADDR: begin
                hc_data_d = DATA_WIDTH'(txn_d.addr);
                hc_doa_d  = 1'b1;
                hc_da_d   = DA_ADDR;
                hc_rw_d   = ~txn_d.we;
            end
            ST_WDATA: begin
                hc_data_d = wdata_d;
                hc_da_d   = DA_DATA;
            end
            ST_RDWAIT: begin
                hc_rw_d = 1'b1;
            end
            default: begin
            end
        endcase

        busy_d = (state_d == ST_EXEC);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            txn_q        <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            start_pend_q <= 1'b0;
            rst_done_q   <= 1'b0;
            gnt_q        <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            rid_q        <= 1'b0;
            rerr_q       <= 1'b0;
            busy_q       <= 1'b0;
            hc_data_q    <= '0;
            hc_doa_q     <= 1'b0;
            hc_rw_q      <= 1'b0;
            hc_da_q      <= DA_NONE;
            hc_start_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            txn_q        <= txn_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            start_pend_q <= start_pend_d;
            rst_done_q   <= 1'b1;
            gnt_q        <= gnt_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            rid_q        <= rid_d;
            rerr_q       <= rerr_d;
            busy_q       <= busy_d;
            hc_data_q    <= hc_data_d;
            hc_doa_q     <= hc_doa_d;
            hc_rw_q      <= hc_rw_d;
            hc_da_q      <= hc_da_d;
            hc_start_q   <= hc_start_d;
        end
    end

    assign bus.gnt             = gnt_q;
    assign bus.rdata           = rdata_q;
    assign bus.rvalid          = rvalid_q;
    assign bus.rid             = rid_q;
    assign bus.rerr            = rerr_q;
    assign bus.busy_exec       = busy_q;
    assign bus.hc_data         = hc_data_q;
    assign bus.hc_data_or_addr = hc_doa_q;
    assign bus.hc_read_write   = hc_rw_q;
    assign bus.hc_da_valid     = hc_da_q;
    assign bus.hc_start_exec   = hc_start_q;

endmodule

// File: tb/tb_hycube_port_arbiter.sv
// Directed bench for hycube_port_arbiter with a transaction-level model
// checked against the DUT on every falling clock edge.
module tb_hycube_port_arbiter;

    localparam int unsigned DW    = 16;
    localparam int          RD_TO = 255;

    localparam int A_NONE = 0;
    localparam int A_WR   = 1;
    localparam int A_RD   = 2;
    localparam int A_EXEC = 3;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    hycube_port_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    hycube_port_arbiter #(.DATA_WIDTH(DW), .RD_TIMEOUT(RD_TO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          m_act, m_age, m_rr;
    bit          m_start_pend, m_armed;
    logic [15:0] m_addr, m_wdata;
    logic [1:0]  e_gnt;
    bit          e_rvalid, e_rid, e_rerr, e_start, m_id;
    logic [15:0] e_rdata;

    function automatic void model_reset();
        m_act = A_NONE; m_age = 0; m_rr = 0; m_id = 1'b0;
        m_start_pend = 1'b0; m_armed = 1'b0;
        m_addr = '0; m_wdata = '0;
        e_gnt = '0; e_rvalid = 1'b0; e_rid = 1'b0; e_rerr = 1'b0; e_start = 1'b0;
        e_rdata = '0;
    endfunction

    function automatic void model_edge();
        int id;
        m_start_pend = m_start_pend | (bus.start_req != 2'b00);
        e_gnt = '0; e_rvalid = 1'b0; e_rid = 1'b0; e_rerr = 1'b0; e_start = 1'b0;
        e_rdata = '0;
        case (m_act)
            A_NONE: begin
                if (m_start_pend) begin
                    m_start_pend = 1'b0;
                    m_act        = A_EXEC;
                    e_start      = 1'b1;
                end else if (m_armed && bus.req != 2'b00) begin
                    id        = bus.req[m_rr] ? m_rr : 1 - m_rr;
                    m_rr      = 1 - id;
                    m_id      = (id == 1);
                    m_addr    = bus.addr_i[id];
                    m_wdata   = bus.wdata_i[id];
                    m_act     = bus.we[id] ? A_WR : A_RD;
                    m_age     = 0;
                    e_gnt[id] = 1'b1;
                end
            end
            A_WR: begin
                m_age++;
                if (m_age == 2) m_act = A_NONE;
            end
            A_RD: begin
                if (m_age == 0) begin
                    m_age = 1;
                end else if (bus.hc_rdata_valid) begin
                    e_rvalid = 1'b1; e_rid = m_id; e_rdata = bus.hc_rdata;
                    m_act = A_NONE;
                end else if (m_age == RD_TO) begin
                    e_rvalid = 1'b1; e_rid = m_id; e_rerr = 1'b1; e_rdata = 16'hDEAD;
                    m_act = A_NONE;
                end else begin
                    m_age++;
                end
            end
            A_EXEC: begin
                if (bus.hc_exec_end) m_act = A_NONE;
            end
            default: ;
        endcase
        m_armed = 1'b1;
    endfunction

    function automatic logic [63:0] model_vec();
        logic [15:0] d;
        logic        doa, rw, busy;
        logic [1:0]  da;
        d = '0; doa = 1'b0; rw = 1'b0; da = 2'b00;
        if (m_act == A_WR || m_act == A_RD) begin
            if (m_age == 0) begin
                d = m_addr; doa = 1'b1; da = 2'b10; rw = (m_act == A_RD);
            end else if (m_act == A_WR) begin
                d = m_wdata; da = 2'b01;
            end else begin
                rw = 1'b1;
            end
        end
        busy = (m_act == A_EXEC);
        return 64'({e_gnt, e_rvalid, e_rid, e_rerr, e_rdata, busy, d, doa, rw, da, e_start});
    endfunction

    function automatic logic [63:0] dut_vec();
        return 64'({bus.gnt, bus.rvalid, bus.rid, bus.rerr, bus.rdata, bus.busy_exec,
                    bus.hc_data, bus.hc_data_or_addr, bus.hc_read_write,
                    bus.hc_da_valid, bus.hc_start_exec});
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) model_reset();
            else       model_edge();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (check_en) check("cycle_model", dut_vec(), model_vec());
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int id, input int bound);
        int waited;
        waited = 0;
        while (bus.gnt[id] !== 1'b1 && waited < bound) begin
            cyc();
            waited++;
        end
        check("gnt_arrives", 64'(bus.gnt[id]), 64'd1);
    endtask

    int n;

    initial begin
        rstn = 1'b1;
        bus.req = '0; bus.we = '0; bus.addr_i = '0; bus.wdata_i = '0; bus.start_req = '0;
        bus.hc_rdata = '0; bus.hc_rdata_valid = 1'b0; bus.hc_exec_end = 1'b0;
        #2 rstn = 1'b0;
        check_en = 1'b1;
        cyc(); cyc();
        check("reset_outputs_zero", dut_vec(), 64'd0);
        rstn = 1'b1;
        cyc();

        // single write from SPI
        bus.req = 2'b01; bus.we = 2'b01;
        bus.addr_i[0] = 16'h0040; bus.wdata_i[0] = 16'h1234;
        wait_gnt(0, 6);
        check("t1_gnt", 64'(bus.gnt), 64'h1);
        check("t1_addr_phase", 64'({bus.hc_data, bus.hc_data_or_addr, bus.hc_read_write, bus.hc_da_valid}),
              64'({16'h0040, 1'b1, 1'b0, 2'b10}));
        bus.req[0] = 1'b0;
        cyc();
        check("t1_data_phase", 64'({bus.gnt, bus.hc_data, bus.hc_data_or_addr, bus.hc_da_valid}),
              64'({2'b00, 16'h1234, 1'b0, 2'b01}));
        cyc();
        check("t1_idle", dut_vec(), 64'd0);

        // reset pulse so the pointer starts at SPI again
        cyc(); rstn = 1'b0;
        cyc(); check("reset2_zero", dut_vec(), 64'd0);
        rstn = 1'b1;
        cyc();

        // simultaneous reads
        bus.req = 2'b11; bus.we = 2'b00;
        bus.addr_i[0] = 16'h0100; bus.addr_i[1] = 16'h0200;
        wait_gnt(0, 6);
        check("t2_first_gnt_onehot", 64'(bus.gnt), 64'h1);
        bus.req[0] = 1'b0;
        cyc();
        cyc(); bus.hc_rdata = 16'hA5A5; bus.hc_rdata_valid = 1'b1;
        cyc(); bus.hc_rdata_valid = 1'b0;
        check("t2_rd0", 64'({bus.rvalid, bus.rid, bus.rerr, bus.rdata, bus.gnt}),
              64'({1'b1, 1'b0, 1'b0, 16'hA5A5, 2'b00}));
        cyc();
        check("t2_second_gnt", 64'({bus.gnt, bus.hc_data}), 64'({2'b10, 16'h0200}));
        bus.req[1] = 1'b0;
        cyc();
        cyc(); bus.hc_rdata = 16'h5A5A; bus.hc_rdata_valid = 1'b1;
        cyc(); bus.hc_rdata_valid = 1'b0;
        check("t2_rd1", 64'({bus.rvalid, bus.rid, bus.rerr, bus.rdata}),
              64'({1'b1, 1'b1, 1'b0, 16'h5A5A}));

        // stray array returns while idle are ignored
        cyc(); bus.hc_exec_end = 1'b1; bus.hc_rdata_valid = 1'b1; bus.hc_rdata = 16'hFFFF;
        cyc(); bus.hc_exec_end = 1'b0; bus.hc_rdata_valid = 1'b0;
        check("stray_ignored", 64'({bus.rvalid, bus.busy_exec, bus.hc_start_exec}), 64'd0);

        // read timeout
        bus.req = 2'b01; bus.we = 2'b00; bus.addr_i[0] = 16'h0300;
        wait_gnt(0, 6);
        bus.req[0] = 1'b0;
        cyc();
        n = 0;
        while (bus.rvalid !== 1'b1 && n < 400) begin
            if (bus.hc_read_write === 1'b1 && bus.hc_da_valid === 2'b00) n++;
            cyc();
        end
        check("t3_wait_cycles", 64'(n), 64'd255);
        check("t3_timeout_ret", 64'({bus.rvalid, bus.rid, bus.rerr, bus.rdata}),
              64'({1'b1, 1'b0, 1'b1, 16'hDEAD}));

        // start beats pending request; duplicate starts coalesce
        cyc();
        bus.req = 2'b01; bus.we = 2'b01; bus.addr_i[0] = 16'h0080; bus.wdata_i[0] = 16'hBEEF;
        bus.start_req = 2'b10;
        cyc(); bus.start_req = 2'b00;
        check("t4_start1", 64'({bus.hc_start_exec, bus.busy_exec, bus.gnt}), 64'({1'b1, 1'b1, 2'b00}));
        cyc(); bus.start_req = 2'b01;
        check("t4_exec_hold", 64'({bus.hc_start_exec, bus.busy_exec, bus.gnt}), 64'({1'b0, 1'b1, 2'b00}));
        cyc(); bus.start_req = 2'b01;
        cyc(); bus.start_req = 2'b00;
        cyc(); bus.hc_exec_end = 1'b1;
        cyc(); bus.hc_exec_end = 1'b0;
        check("t4_exec_done", 64'({bus.hc_start_exec, bus.busy_exec, bus.gnt}), 64'd0);
        cyc();
        check("t4_start2", 64'({bus.hc_start_exec, bus.busy_exec, bus.gnt}), 64'({1'b1, 1'b1, 2'b00}));
        cyc(); bus.hc_exec_end = 1'b1;
        cyc(); bus.hc_exec_end = 1'b0;
        check("t4_exec2_done", 64'({bus.busy_exec, bus.gnt}), 64'd0);
        cyc();
        check("t4_gnt_after_exec", 64'({bus.gnt, bus.hc_data, bus.hc_da_valid}),
              64'({2'b01, 16'h0080, 2'b10}));
        bus.req = 2'b00;
        cyc();
        check("t4_wdata", 64'({bus.hc_data, bus.hc_da_valid}), 64'({16'hBEEF, 2'b01}));
        cyc();
        check("t4_no_third_start", 64'({bus.hc_start_exec, bus.busy_exec}), 64'd0);

        // reset during read wait
        bus.req = 2'b01; bus.we = 2'b00; bus.addr_i[0] = 16'h0400;
        wait_gnt(0, 6);
        bus.req[0] = 1'b0;
        cyc(); cyc();
        rstn = 1'b0;
        bus.req = 2'b10; bus.we = 2'b10; bus.addr_i[1] = 16'h0500; bus.wdata_i[1] = 16'h5555;
        cyc();
        check("t5_reset_zero", dut_vec(), 64'd0);
        bus.hc_rdata = 16'h7777; bus.hc_rdata_valid = 1'b1;
        cyc();
        check("t5_reset_zero2", dut_vec(), 64'd0);
        rstn = 1'b1;
        cyc(); bus.hc_rdata_valid = 1'b0;
        check("t5_first_cycle", 64'({bus.gnt, bus.rvalid}), 64'd0);
        cyc();
        check("t5_gnt1", 64'({bus.gnt, bus.rvalid, bus.hc_data, bus.hc_read_write}),
              64'({2'b10, 1'b0, 16'h0500, 1'b0}));
        bus.req = 2'b00;
        cyc();
        check("t5_wdata", 64'({bus.hc_data, bus.hc_da_valid}), 64'({16'h5555, 2'b01}));
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
